// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: PROM bit map, default horizontal timing,
// and the flag structs used by video_sync_sequencer and hcounter_gen.
package video_timing_pkg;

  localparam int VSYNC_BIT   = 0;
  localparam int VBLANK_BIT  = 1;
  localparam int VRELOAD_BIT = 2;
  localparam int VWIN_BIT    = 3;

  localparam int H_TOTAL_DEF       = 384;
  localparam int H_BLANK_START_DEF = 256;
  localparam int H_SYNC_START_DEF  = 272;
  localparam int H_SYNC_END_DEF    = 304;
  localparam int H_LATCH_DEF       = 2;

  localparam logic [7:0] V_RELOAD_DEF   = 8'h00;
  localparam int         WDOG_LINES_DEF = 300;

  // Latched vertical outputs, held for one line.
  typedef struct packed {
    logic vwin;
    logic vblank;
    logic vsync;
  } vflags_t;

  // Decoded view of one PROM word.
  typedef struct packed {
    logic vwin;
    logic vreload;
    logic vblank;
    logic vsync;
  } prom_word_t;

  function automatic prom_word_t decode_prom(input logic [3:0] word);
    prom_word_t pw;
    pw.vsync   = word[VSYNC_BIT];
    pw.vblank  = word[VBLANK_BIT];
    pw.vreload = word[VRELOAD_BIT];
    pw.vwin    = word[VWIN_BIT];
    return pw;
  endfunction

endpackage

// File: rtl/video_sync_sequencer_if.sv
// Horizontal timing bus between hcounter_gen (master) and the vertical/PROM
// logic of video_sync_sequencer (slave).
interface video_sync_sequencer_if;

  // ce_pix qualifies every transfer; line_end is a single-cycle strobe that is
  // only ever high in a cycle where ce_pix is high and hcount is the last pixel.
  logic       ce_pix;
  logic [8:0] hcount;
  logic       hsync;
  logic       hblank;
  logic       line_end;

  modport master (
    input  ce_pix,
    output hcount,
    output hsync,
    output hblank,
    output line_end
  );

  modport slave (
    output ce_pix,
    input  hcount,
    input  hsync,
    input  hblank,
    input  line_end
  );

endinterface

// File: rtl/hcounter_gen.sv
// Horizontal pixel counter with registered hsync/hblank compares and the
// ce-qualified line-end strobe.
module hcounter_gen
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL       = H_TOTAL_DEF,
  parameter int H_BLANK_START = H_BLANK_START_DEF,
  parameter int H_SYNC_START  = H_SYNC_START_DEF,
  parameter int H_SYNC_END    = H_SYNC_END_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  video_sync_sequencer_if.master tim
);

  logic [8:0] hcount_q, hcount_d;
  logic       hsync_q, hsync_d;
  logic       hblank_q, hblank_d;
  logic       at_last;

  assign at_last = (hcount_q == 9'(H_TOTAL - 1));

  // Compares look at the next count so the registered flags line up with hcount.
  always_comb begin
    hcount_d = at_last ? 9'd0 : hcount_q + 9'd1;
    hblank_d = (hcount_d >= 9'(H_BLANK_START)) && (hcount_d <= 9'(H_TOTAL - 1));
    hsync_d  = (hcount_d >= 9'(H_SYNC_START)) && (hcount_d < 9'(H_SYNC_END));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q <= 9'd0;
      hsync_q  <= 1'b0;
      hblank_q <= 1'b0;
    end else if (tim.ce_pix) begin
      hcount_q <= hcount_d;
      hsync_q  <= hsync_d;
      hblank_q <= hblank_d;
    end
  end

  assign tim.hcount   = hcount_q;
  assign tim.hsync    = hsync_q;
  assign tim.hblank   = hblank_q;
  assign tim.line_end = tim.ce_pix && at_last;

endmodule

// File: rtl/video_sync_sequencer.sv
// Vertical timing PROM reader: owns the line counter, latches the PROM word once
// per line and produces vsync/vblank/vwin plus the frame-start strobe.
// Optional line watchdog: define SYNC_SEQ_WATCHDOG_EN.
module video_sync_sequencer
  import video_timing_pkg::*;
#(
  parameter int         H_TOTAL       = H_TOTAL_DEF,
  parameter int         H_BLANK_START = H_BLANK_START_DEF,
  parameter int         H_SYNC_START  = H_SYNC_START_DEF,
  parameter int         H_SYNC_END    = H_SYNC_END_DEF,
  parameter int         H_LATCH       = H_LATCH_DEF,
  parameter logic [7:0] V_RELOAD      = V_RELOAD_DEF
`ifdef SYNC_SEQ_WATCHDOG_EN
  ,
  parameter int         WDOG_LINES    = WDOG_LINES_DEF
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce_pix,
  output logic [7:0] prom_addr,
  input  logic [3:0] prom_data,
  output logic [8:0] hcount,
  output logic [7:0] vcount,
  output logic       hsync,
  output logic       hblank,
  output logic       vsync,
  output logic       vblank,
  output logic       vwin,
  output logic       frame_start,
  output logic       wdog_err
);

  video_sync_sequencer_if tim ();

  assign tim.ce_pix = ce_pix;

  hcounter_gen #(
    .H_TOTAL       (H_TOTAL),
    .H_BLANK_START (H_BLANK_START),
    .H_SYNC_START  (H_SYNC_START),
    .H_SYNC_END    (H_SYNC_END)
  ) u_hcounter (
    .clk (clock),
    .rst (reset),
    .tim (tim)
  );

  logic [7:0] vcount_q, vcount_d;
  vflags_t    vflags_q, vflags_d;
  logic       reload_q, reload_d;
  logic       frame_start_q, frame_start_d;
  logic       latch_now;
  logic       wdog_trip;
  logic       do_reload;
  prom_word_t pw;

  assign pw        = decode_prom(prom_data);
  assign latch_now = ce_pix && (tim.hcount == 9'(H_LATCH));
  assign do_reload = reload_q || wdog_trip;

`ifdef SYNC_SEQ_WATCHDOG_EN
  logic [8:0] wdog_cnt_q, wdog_cnt_d;
  logic       wdog_err_q, wdog_err_d;

  // Trips on the line end that would complete WDOG_LINES lines without a reload.
  assign wdog_trip = tim.line_end && !reload_q && ((wdog_cnt_q + 9'd1) == 9'(WDOG_LINES));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q;
    if (tim.line_end) begin
      if (do_reload) wdog_cnt_d = 9'd0;
      else           wdog_cnt_d = wdog_cnt_q + 9'd1;
      if (wdog_trip) wdog_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt_q <= 9'd0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  // The reload flag is armed at H_LATCH and consumed at line end of the same line.
  always_comb begin
    vcount_d      = vcount_q;
    vflags_d      = vflags_q;
    reload_d      = reload_q;
    frame_start_d = frame_start_q;
    if (ce_pix) begin
      frame_start_d = tim.line_end && do_reload;
      if (latch_now) begin
        vflags_d.vsync  = pw.vsync;
        vflags_d.vblank = pw.vblank;
        vflags_d.vwin   = pw.vwin;
        if (pw.vreload) reload_d = 1'b1;
      end
      if (tim.line_end) begin
        if (do_reload) begin
          vcount_d = V_RELOAD;
          reload_d = 1'b0;
        end else begin
          vcount_d = vcount_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vcount_q      <= V_RELOAD;
      vflags_q      <= '0;
      reload_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vcount_q      <= vcount_d;
      vflags_q      <= vflags_d;
      reload_q      <= reload_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign prom_addr   = vcount_q;
  assign vcount      = vcount_q;
  assign hcount      = tim.hcount;
  assign hsync       = tim.hsync;
  assign hblank      = tim.hblank;
  assign vsync       = vflags_q.vsync;
  assign vblank      = vflags_q.vblank;
  assign vwin        = vflags_q.vwin;
  assign frame_start = frame_start_q;

  a_hcount_range : assert property (@(posedge clock) disable iff (reset)
    hcount <= 9'(H_TOTAL - 1));
  a_fs_at_line_start : assert property (@(posedge clock) disable iff (reset)
    frame_start |-> (hcount == 9'd0));

endmodule

// File: tb/tb_video_sync_sequencer.sv
// Bench for video_sync_sequencer: boundary table, hand sequences for reset,
// reload and ce_pix gaps, and randomized PROM/ce_pix runs against a line model.
module tb_video_sync_sequencer;
  import video_timing_pkg::*;

  // Shortened line keeps full-frame runs short; sync span stays 32, blank span 128.
  localparam int         HT   = 144;
  localparam int         HBS  = 16;
  localparam int         HSS  = 24;
  localparam int         HSE  = 56;
  localparam int         HL   = 2;
  localparam logic [7:0] VR   = 8'h00;
  localparam int         WDOG = 300;
  localparam logic [31:0] RST_VEC = {9'd0, VR, VR, 7'b0};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] prom_data;
  logic [7:0] prom_addr, vcount;
  logic       vsync, vblank, vwin, frame_start, wdog_err;
  logic [3:0] prom_mem [256];

  video_sync_sequencer_if vif ();

  video_sync_sequencer #(
    .H_TOTAL (HT), .H_BLANK_START (HBS), .H_SYNC_START (HSS),
    .H_SYNC_END (HSE), .H_LATCH (HL), .V_RELOAD (VR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ce_pix      (vif.ce_pix),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .hcount      (vif.hcount),
    .vcount      (vcount),
    .hsync       (vif.hsync),
    .hblank      (vif.hblank),
    .vsync       (vsync),
    .vblank      (vblank),
    .vwin        (vwin),
    .frame_start (frame_start),
    .wdog_err    (wdog_err)
  );

  always #5 clock = ~clock;

  // PROM with one clock of read latency.
  always @(posedge clock) prom_data <= prom_mem[prom_addr];

  assign vif.line_end = vif.ce_pix && (vif.hcount == 9'(HT - 1));
  int le_cnt = 0;
  always @(posedge clock) if (vif.line_end) le_cnt <= le_cnt + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  // ---------------- reference model: position in frame plus per-line PROM words
  int         m_h, m_v, m_line, m_lines_wd;
  logic [3:0] m_old;
  bit         m_fs_line, m_err;

  task automatic model_reset();
    m_h = 0; m_v = int'(VR); m_line = 0; m_lines_wd = 0;
    m_old = 4'b0; m_fs_line = 0; m_err = 0;
  endtask

  task automatic model_advance();
    logic [3:0] w;
    bit rl;
    if (m_h == HT - 1) begin
      w  = prom_mem[m_v];
      rl = w[VRELOAD_BIT];
      m_old = w;
      m_h = 0;
      m_line++;
`ifdef SYNC_SEQ_WATCHDOG_EN
      m_lines_wd++;
      if (!rl && m_lines_wd == WDOG) begin rl = 1; m_err = 1; end
      if (rl) m_lines_wd = 0;
`endif
      m_v = rl ? int'(VR) : (m_v + 1) % 256;
      m_fs_line = rl;
    end else begin
      m_h++;
    end
  endtask

  function automatic logic [31:0] exp_vec();
    logic [3:0] w;
    logic hs, hb, fs;
    w  = (m_h >= HL + 1) ? prom_mem[m_v] : m_old;
    hs = (m_h >= HSS) && (m_h < HSE);
    hb = (m_h >= HBS) && (m_h <= HT - 1);
    fs = m_fs_line && (m_h == 0);
    return {9'(m_h), 8'(m_v), 8'(m_v), hs, hb, w[VSYNC_BIT], w[VBLANK_BIT], w[VWIN_BIT], fs, m_err};
  endfunction

  function automatic logic [31:0] act_vec();
    return {vif.hcount, vcount, prom_addr, vif.hsync, vif.hblank, vsync, vblank, vwin,
            frame_start, wdog_err};
  endfunction

  task automatic report();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] a, e;
    a = act_vec();
    e = exp_vec();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL model line=%0d actual h=%0d v=%h addr=%h hs,hb,vs,vb,vw,fs,we=%b expected h=%0d v=%h addr=%h hs,hb,vs,vb,vw,fs,we=%b",
               m_line, a[31:23], a[22:15], a[14:7], a[6:0], e[31:23], e[22:15], e[14:7], e[6:0]);
      if (errors >= 40) begin
        $display("FAIL abort: error limit reached");
        report();
        $finish;
      end
    end
  endtask

  task automatic step(input logic ce);
    vif.ce_pix = ce;
    @(posedge clock);
    if (ce) model_advance();
    @(negedge clock);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    vif.ce_pix = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    check("reset_state", act_vec(), RST_VEC);
  endtask

  // ---------------- boundary table
  typedef struct {
    int         line;
    int         pix;
    logic [7:0] vcnt;
    logic       hs;
    logic       hb;
    logic [2:0] flags;  // {vwin, vblank, vsync}
    logic       fs;
  } vec_t;

  vec_t tbl [21];

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation time limit reached");
    report();
    $finish;
  end

  initial begin
    int n, hs_cnt, hb_cnt, fs_cycles, le0;

    tbl[0]  = '{0,   1,   8'h00, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[1]  = '{0,   3,   8'h00, 1'b0, 1'b0, 3'b111, 1'b0};
    tbl[2]  = '{1,   2,   8'h01, 1'b0, 1'b0, 3'b111, 1'b0};
    tbl[3]  = '{1,   3,   8'h01, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[4]  = '{1,   15,  8'h01, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[5]  = '{1,   16,  8'h01, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[6]  = '{1,   23,  8'h01, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[7]  = '{1,   24,  8'h01, 1'b1, 1'b1, 3'b000, 1'b0};
    tbl[8]  = '{1,   55,  8'h01, 1'b1, 1'b1, 3'b000, 1'b0};
    tbl[9]  = '{1,   56,  8'h01, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[10] = '{1,   143, 8'h01, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[11] = '{2,   0,   8'h02, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[12] = '{5,   2,   8'h05, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[13] = '{5,   3,   8'h05, 1'b0, 1'b0, 3'b011, 1'b0};
    tbl[14] = '{6,   2,   8'h06, 1'b0, 1'b0, 3'b011, 1'b0};
    tbl[15] = '{6,   3,   8'h06, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[16] = '{224, 2,   8'hE0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[17] = '{224, 3,   8'hE0, 1'b0, 1'b0, 3'b100, 1'b0};
    tbl[18] = '{255, 143, 8'hFF, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[19] = '{256, 0,   8'h00, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[20] = '{256, 3,   8'h00, 1'b0, 1'b0, 3'b111, 1'b0};

    // PROM image: random flags without reload, fixed words around the checked lines.
    for (int a = 0; a < 256; a++) prom_mem[a] = 4'($urandom) & 4'b1011;
    prom_mem[0] = 4'b1011;
    for (int a = 1; a <= 4; a++) prom_mem[a] = 4'b0000;
    prom_mem[5] = 4'b0011;  prom_mem[6] = 4'b0000;
    prom_mem[8'hDF] = 4'b0000; prom_mem[8'hE0] = 4'b1000;
    prom_mem[8'hE1] = 4'b0000; prom_mem[8'hFF] = 4'b0000;

    // ---- reset, then reset again in the middle of line 0
    vif.ce_pix = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_state", act_vec(), RST_VEC);
    reset = 1'b0;
    repeat (100) step(1'b1);
    check("pre_reset_hcount", 32'(vif.hcount), 32'd100);
    check("pre_reset_flags", {28'd0, vwin, vblank, vsync, vif.hblank}, 32'hF);
    #2 reset = 1'b1;
    #1 check("midline_reset", act_vec(), RST_VEC);
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    // ---- boundary table across a full 256-line wrap with no reload bit
    for (int i = 0; i < 21; i++) begin
      n = 0;
      while (!(m_line == tbl[i].line && m_h == tbl[i].pix) && n < 260 * HT) begin
        step(1'b1);
        n++;
      end
      if (n >= 260 * HT) begin
        checks++; errors++;
        $display("FAIL tbl_reach[%0d] actual=timeout required=line %0d pix %0d", i, tbl[i].line, tbl[i].pix);
      end else begin
        check($sformatf("tbl[%0d]", i),
              {18'd0, vcount, vif.hsync, vif.hblank, vwin, vblank, vsync, frame_start},
              {18'd0, tbl[i].vcnt, tbl[i].hs, tbl[i].hb, tbl[i].flags, tbl[i].fs});
      end
    end

    // ---- reload at line 0x85: frame of 134 lines, single frame_start, held over ce gaps
    for (int a = 0; a < 256; a++) prom_mem[a] = 4'($urandom) & 4'b1011;
    prom_mem[8'h85] = prom_mem[8'h85] | 4'b0100;
    do_reset();
    exp_q.push_back(32'(134 * HT));
    le0 = le_cnt;
    n = 0;
    while (frame_start !== 1'b1 && n < 200 * HT) begin
      step(1'b1);
      n++;
    end
    check("frame_len", 32'(n), exp_q.pop_front());
    check("line_ends", 32'(le_cnt - le0), 32'd134);
    check("reload_vcount", {24'd0, vcount}, {24'd0, VR});
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      check("fs_hold_ce_low", {31'd0, frame_start}, 32'd1);
    end
    fs_cycles = 0;
    for (int k = 0; k < 3 * HT; k++) begin
      step(1'b1);
      if (frame_start) fs_cycles++;
    end
    check("fs_single", 32'(fs_cycles), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    // ---- random PROM (occasional reloads) with random ce_pix
    for (int a = 0; a < 256; a++) begin
      prom_mem[a] = 4'($urandom) & 4'b1011;
      if ($urandom_range(0, 9) == 0) prom_mem[a] = prom_mem[a] | 4'b0100;
    end
    do_reset();
    for (int k = 0; k < 25 * HT * 4 / 3; k++) step($urandom_range(0, 3) != 0);

    // ---- ce_pix every second clock over one full line
    for (int a = 0; a < 256; a++) prom_mem[a] = 4'b0000;
    do_reset();
    hs_cnt = 0;
    hb_cnt = 0;
    for (int p = 0; p < HT; p++) begin
      step(1'b0);
      if (vif.hsync)  hs_cnt++;
      if (vif.hblank) hb_cnt++;
      step(1'b1);
    end
    check("hsync_pixels", 32'(hs_cnt), 32'd32);
    check("hblank_pixels", 32'(hb_cnt), 32'd128);
    check("sweep_end_pos", {15'd0, vif.hcount, vcount}, {15'd0, 9'd0, 8'h01});

`ifdef SYNC_SEQ_WATCHDOG_EN
    // ---- no reload bit anywhere: watchdog forces the reload
    do_reset();
    n = 0;
    while (wdog_err !== 1'b1 && n < 310 * HT) begin
      step(1'b1);
      n++;
    end
    check("wdog_len", 32'(n), 32'(WDOG * HT));
    check("wdog_reload", {22'd0, vcount, frame_start, wdog_err}, {22'd0, VR, 1'b1, 1'b1});
    repeat (2 * HT) step(1'b1);
    check("wdog_sticky", {31'd0, wdog_err}, 32'd1);
`else
    // ---- no reload bit anywhere: vcount free-runs through the wrap
    do_reset();
    fs_cycles = 0;
    for (int k = 0; k < 256 * HT + 4; k++) begin
      step(1'b1);
      if (frame_start) fs_cycles++;
    end
    check("wrap_no_fs", 32'(fs_cycles), 32'd0);
    check("wrap_vcount", {24'd0, vcount}, 32'h00);
`endif

    report();
    $finish;
  end

endmodule

// File: doc/video_sync_sequencer.md
Name: video_sync_sequencer

Overview:
- Reader side of the vertical-timing PROM. Owns the horizontal pixel counter and the vertical line counter.
- Drives the line counter onto the PROM address bus and registers the 4-bit PROM word at a fixed point in each line.
- Produces hsync/hblank from horizontal compares and vsync/vblank/vwin from the PROM word, plus a frame-start strobe for the video and CPU interrupt logic.

Parameters:
- H_TOTAL, 384, pixel clocks per line (counter runs 0..H_TOTAL-1)
- H_BLANK_START, 256, hcount at which hblank asserts
- H_SYNC_START, 272, hcount at which hsync asserts
- H_SYNC_END, 304, hcount at which hsync deasserts
- H_LATCH, 2, hcount at which the PROM word for the current line is latched; must be >= 1
- V_RELOAD, 8'h00, value loaded into vcount on a PROM reload line
- WDOG_LINES, 300, line limit for the watchdog (only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_pix  in  1  pixel clock enable; all counters advance only when high
- prom_addr  out  8  PROM address, always equal to vcount
- prom_data  in  4  PROM output; valid one clock after prom_addr changes
- hcount  out  9  horizontal pixel counter
- vcount  out  8  vertical line counter
- hsync  out  1  horizontal sync, active high
- hblank  out  1  horizontal blank, active high
- vsync  out  1  latched prom_data[0]
- vblank  out  1  latched prom_data[1]
- vwin  out  1  latched prom_data[3], the vertical window flag
- frame_start  out  1  one-clock pulse on the first ce_pix of the line after a reload
- wdog_err  out  1  sticky watchdog error (tied 0 without the optional feature)

Behaviour:
- Reset (async):
  - hcount=0, vcount=V_RELOAD.
  - hsync, hblank, vsync, vblank, vwin, frame_start and wdog_err all 0.
  - Internal reload flag cleared.
- Horizontal counter:
  - On each ce_pix, hcount increments; at H_TOTAL-1 it wraps to 0.
  - hblank is registered: 1 when H_BLANK_START <= next hcount <= H_TOTAL-1.
  - hsync is registered: 1 when H_SYNC_START <= next hcount < H_SYNC_END.
- Line end is the ce_pix with hcount==H_TOTAL-1. At line end:
  - If the reload flag is set, vcount<=V_RELOAD, the flag clears, and frame_start pulses on the next ce_pix cycle.
  - Otherwise vcount increments, wrapping 8'hFF to 8'h00.
- PROM timing:
  - prom_addr = vcount, combinational from the register.
  - On the ce_pix with hcount==H_LATCH, register prom_data into vsync, vblank and vwin. These outputs lag the line start by H_LATCH+1 pixels, which is deterministic.
  - prom_data[2]=1 at that latch sets the reload flag for this line's end.
- Simultaneous events: the reload flag is set at H_LATCH and consumed at line end, so both cannot occur in the same cycle when H_LATCH < H_TOTAL-1.
- ce_pix low: all state holds, including the one-clock frame_start pulse, which is held until the next ce_pix.
- Reset mid-line: all state returns to reset values immediately. vsync/vblank stay 0 until the first H_LATCH after reset.

Optional Feature:
- Macro: SYNC_SEQ_WATCHDOG_EN.
- Defined:
  - A 9-bit line counter clears on every reload and increments at each line end.
  - If it reaches WDOG_LINES, force reload at that line end (vcount<=V_RELOAD, frame_start pulses) and set wdog_err.
  - wdog_err clears only on reset.
- Undefined: no counter; wdog_err tied 0; a PROM with no reload bit free-runs vcount mod 256.

Decomposition:
- Shared package video_timing_pkg holds:
  - PROM bit-index constants: VSYNC_BIT=0, VBLANK_BIT=1, VRELOAD_BIT=2, VWIN_BIT=3.
  - Default H_* constants.
  - A packed struct for the vertical flags.
- One sub-module, hcounter_gen: horizontal counter with hsync/hblank compares and the line-end strobe. The vertical/PROM logic stays in the top.

Test Plan:
- Reset asserted mid-line at hcount=100 -> all outputs 0 and hcount=0 the same cycle; vcount=0x00 until the first line end.
- Model PROM returns 4'b0011 at addr 0x05 -> vsync=1 and vblank=1 from pixel H_LATCH+1 of line 5 through pixel H_LATCH of line 6.
- Model PROM sets bit2 at addr 0x85 -> after line 0x85, vcount=0x00, frame_start is a single pulse; frame length is 134 lines x 384 pixels.
- hcount sweep with ce_pix every 2nd clock -> hsync high for exactly 32 ce_pix (272..303), hblank for 128; no change on clocks with ce_pix=0.
- PROM all zeros -> vcount wraps 0xFF->0x00 with no frame_start; with SYNC_SEQ_WATCHDOG_EN, forced reload after 300 lines and wdog_err=1.
- PROM returns 4'b1000 at addr 0xE0 -> vwin=1 latched at H_LATCH with vsync=0 and vblank=0.
